// File: rtl/cs_multi_gen.sv
// cs_multi_gen: multi-channel checksum engine folding one CHUNK per channel per cycle.
// Supports add, one's-complement, XOR and negated-add checksums with per-channel masking.
module cs_multi_gen #(
  parameter int NUM_CH       = 2,
  parameter int WIDTH_DATA   = 384,
  parameter int WIDTH_RESULT = 8,
  parameter int CHUNK        = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [NUM_CH*WIDTH_DATA-1:0]   data,
  input  logic [1:0]                     mode,
  input  logic [NUM_CH-1:0]              ch_mask,
  output logic [NUM_CH*WIDTH_RESULT-1:0] result,
  output logic                           out_valid,
  output logic                           busy
);
  localparam int N    = WIDTH_DATA / CHUNK;
  localparam int WPC  = CHUNK / WIDTH_RESULT;
  localparam int ACCW = WIDTH_RESULT + $clog2(WIDTH_DATA / WIDTH_RESULT) + 1;
  localparam int CW   = N > 1 ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACC, FIN} state_t;

  state_t                          state_q;
  logic [NUM_CH*WIDTH_DATA-1:0]    data_q, data_d;
  logic [1:0]                      mode_q;
  logic [NUM_CH-1:0]               mask_q;
  logic [CW-1:0]                   cnt_q;
  logic [ACCW-1:0]                 acc_q [NUM_CH];
  logic [ACCW-1:0]                 acc_d [NUM_CH];
  logic [ACCW-1:0]                 fold_s;
  logic [NUM_CH*WIDTH_RESULT-1:0]  fin_d, result_q;
  logic                            out_valid_q;

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = state_q != IDLE;

  // The payload register shifts right each cycle so the current chunk always sits at the LSBs.
  always_comb begin
    data_d = data_q;
    acc_d  = acc_q;
    fin_d  = '0;
    fold_s = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      data_d[k*WIDTH_DATA +: WIDTH_DATA] = data_q[k*WIDTH_DATA +: WIDTH_DATA] >> CHUNK;
      for (int w = 0; w < WPC; w++)
        acc_d[k] = mode_q == 2'd2
          ? acc_d[k] ^ ACCW'(data_q[k*WIDTH_DATA + w*WIDTH_RESULT +: WIDTH_RESULT])
          : acc_d[k] + ACCW'(data_q[k*WIDTH_DATA + w*WIDTH_RESULT +: WIDTH_RESULT]);
      fold_s = acc_q[k];
      for (int i = 0; i < ACCW; i++)
        fold_s = ACCW'(fold_s[WIDTH_RESULT-1:0]) + (fold_s >> WIDTH_RESULT);
      fin_d[k*WIDTH_RESULT +: WIDTH_RESULT] =
        !mask_q[k]      ? '0 :
        mode_q == 2'd1  ? ~fold_s[WIDTH_RESULT-1:0] :
        mode_q == 2'd3  ? WIDTH_RESULT'(0) - acc_q[k][WIDTH_RESULT-1:0] :
                          acc_q[k][WIDTH_RESULT-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mode_q      <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '{default: '0};
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      case (state_q)
        IDLE: if (in_valid) begin
          data_q  <= data;
          mode_q  <= mode;
          mask_q  <= ch_mask;
          cnt_q   <= '0;
          acc_q   <= '{default: '0};
          state_q <= ACC;
        end
        ACC: begin
          acc_q   <= acc_d;
          data_q  <= data_d;
          cnt_q   <= cnt_q + CW'(1);
          state_q <= cnt_q == CW'(N - 1) ? FIN : ACC;
        end
        FIN: begin
          result_q    <= fin_d;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cs_multi_gen.sv
// tb_cs_multi_gen: directed and random requests checked against a byte-level checksum model.
module tb_cs_multi_gen;
  localparam int DW = 2 * 384;
  localparam int RW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] data;
  logic [1:0]    mode;
  logic [1:0]    ch_mask;
  logic [RW-1:0] result;
  logic          out_valid;
  logic          busy;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  cs_multi_gen dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .data(data), .mode(mode),
    .ch_mask(ch_mask), .result(result), .out_valid(out_valid), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] model(input logic [DW-1:0] d, input logic [1:0] m,
                                          input logic [1:0] msk);
    logic [RW-1:0] r = '0;
    for (int k = 0; k < 2; k++) begin
      int s = 0;
      int x = 0;
      int v;
      for (int i = 0; i < 48; i++) begin
        v = int'(d[k*384 + i*8 +: 8]);
        s += v;
        x ^= v;
      end
      case (m)
        2'd0: v = s % 256;
        2'd1: begin
          v = s;
          while (v > 255) v = (v % 256) + (v / 256);
          v = 255 - v;
        end
        2'd2: v = x;
        default: v = (256 - (s % 256)) % 256;
      endcase
      if (msk[k]) r[k*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Issue one request; optionally pulse in_valid again ipulse cycles after acceptance.
  task automatic do_req(input logic [DW-1:0] d, input logic [1:0] m, input logic [1:0] msk,
                        input logic [RW-1:0] exp, input int ipulse);
    int n = 0;
    @(negedge clk);
    data = d; mode = m; ch_mask = msk; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    data = rand_data(); mode = 2'($urandom); ch_mask = 2'($urandom);
    chk("busy_accept", busy, 1'b1);
    chk("ov_low_after_accept", out_valid, 1'b0);
    chk("res_zero_idle", result, '0);
    while (!out_valid && n < 20) begin
      in_valid = n == ipulse;
      if (n == ipulse) begin data = rand_data(); mode = 2'($urandom); ch_mask = 2'($urandom); end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, 7);
    chk("result", result, exp);
    chk("busy_done", busy, 1'b0);
  endtask

  task automatic quiet(input int cycles, input string tag);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk(tag, pulses, 0);
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    m, msk;
    rst_n = 1'b0; in_valid = 1'b0; data = '0; mode = '0; ch_mask = 2'b11;
    #1;
    chk("rst_ov", out_valid, 1'b0);
    chk("rst_res", result, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    d = {{48{8'hFF}}, {48{8'h01}}};
    do_req(d, 2'd0, 2'b11, 16'hD030, -1);
    do_req(d, 2'd1, 2'b11, 16'h00CF, -1);
    do_req(d, 2'd3, 2'b11, 16'h30D0, -1);
    d = '0; d[7:0] = 8'hA5; d[DW-1:384] = '1;
    do_req(d, 2'd2, 2'b01, 16'h00A5, -1);

    d = {{48{8'hFF}}, {48{8'h01}}};
    do_req(d, 2'd0, 2'b11, 16'hD030, 3);
    d = rand_data();
    do_req(d, 2'd1, 2'b10, model(d, 2'd1, 2'b10), 6);
    quiet(10, "no_extra_ov");

    d = rand_data();
    @(negedge clk);
    data = d; mode = 2'd0; ch_mask = 2'b11; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ov", out_valid, 1'b0);
    chk("abort_res", result, '0);
    chk("abort_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    quiet(20, "abort_no_ov");

    for (int t = 0; t < 40; t++) begin
      d = rand_data();
      m = 2'($urandom);
      msk = 2'($urandom);
      if (t % 8 == 0) for (int i = 0; i < 96; i++) d[i*8 +: 8] = 8'hFF;
      do_req(d, m, msk, model(d, m, msk), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1);
    end
    quiet(5, "tail_quiet");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/cs_multi_gen.md
CS_MULTI_GEN -- requirements
Module: cs_multi_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of independent checksum channels (legal 1..8).
REQ-002 SHALL have parameter WIDTH_DATA, default 384, payload bits per channel.
REQ-003 SHALL have parameter WIDTH_RESULT, default 8, checksum word width (legal 8 or 16).
REQ-004 SHALL have parameter CHUNK, default 64, bits folded per channel per cycle; WIDTH_DATA % CHUNK == 0 and CHUNK % WIDTH_RESULT == 0; N = WIDTH_DATA/CHUNK.
REQ-005 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid, input, 1, single-cycle request strobe.
REQ-008 SHALL have port data, input, NUM_CH*WIDTH_DATA, payload; channel k at bits [k*WIDTH_DATA +: WIDTH_DATA].
REQ-009 SHALL have port mode, input, 2, algorithm select, sampled with in_valid.
REQ-010 SHALL have port ch_mask, input, NUM_CH, per-channel enable, sampled with in_valid.
REQ-011 SHALL have port result, output, NUM_CH*WIDTH_RESULT, checksums; channel k at [k*WIDTH_RESULT +: WIDTH_RESULT].
REQ-012 SHALL have port out_valid, output, 1, result-valid strobe.
REQ-013 SHALL have port busy, output, 1, high from the accepting edge until the edge that raises out_valid.

Function
REQ-014 SHALL implement FSM IDLE -> ACC -> FIN -> IDLE.
REQ-015 IDLE: on edge with in_valid=1, latch data, mode, ch_mask; clear accumulators and chunk counter; go ACC.
REQ-016 ACC: each edge fold chunk[cnt] (chunk 0 = LSBs) of every channel into its accumulator, cnt++; after chunk N-1 go FIN.
REQ-017 FIN: finalize, register result, assert out_valid for exactly one cycle, go IDLE.
REQ-018 Latency: out_valid SHALL rise at the (N+1)th rising edge after the accepting edge (7 cycles at defaults).
REQ-019 Words: each chunk split into CHUNK/WIDTH_RESULT words, LSB word first.
REQ-020 mode 0: result = sum of all words mod 2^WIDTH_RESULT.
REQ-021 mode 1: one's-complement sum (accumulator carries folded back end-around until width fits), then bitwise inverted.
REQ-022 mode 2: XOR of all words.
REQ-023 mode 3: two's-complement negation of mode-0 sum, mod 2^WIDTH_RESULT.
REQ-024 Accumulator width SHALL be wide enough that no carry is lost before FIN folding (WIDTH_RESULT + clog2(WIDTH_DATA/WIDTH_RESULT) bits minimum).
REQ-025 Channel with ch_mask bit 0 SHALL output all-zero result field regardless of mode.
REQ-026 result SHALL be all-zero whenever out_valid is 0.
REQ-027 in_valid while busy=1 SHALL be ignored, no queuing; in_valid on the same edge out_valid rises SHALL also be ignored.
REQ-028 in_valid in the cycle after out_valid (FSM in IDLE) SHALL be accepted.
REQ-029 data/mode/ch_mask changes after the accepting edge SHALL NOT affect the in-flight computation.

Reset
REQ-030 On rst_n low, asynchronously: FSM to IDLE, out_valid=0, result=0, busy=0, counter and accumulators 0.
REQ-031 rst_n asserted mid-operation SHALL abort the computation; no out_valid for it after release.
REQ-032 First request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (defaults: NUM_CH=2, WIDTH_DATA=384, WIDTH_RESULT=8, CHUNK=64, ch_mask=2'b11)
REQ-033 Reset: rst_n=0 with out_valid/result X-free checks -> out_valid=0, result=16'h0000, busy=0 before first clock.
REQ-034 mode 0, ch0 all bytes 0x01, ch1 all bytes 0xFF -> result=16'hD030, out_valid high one cycle, 7 cycles after accept.
REQ-035 mode 1, same data -> result=16'h00CF; mode 3, same data -> result=16'h30D0.
REQ-036 mode 2, ch0 byte0=0xA5 rest 0x00, ch1 all 0xFF, ch_mask=2'b01 -> result=16'h00A5.
REQ-037 Second in_valid pulsed 3 cycles into a request -> single out_valid, first result only; new request the cycle after out_valid -> accepted, correct result 7 cycles later.
REQ-038 rst_n low during ACC cycle 3 -> out_valid/result/busy 0 immediately; no out_valid within 20 cycles after release without new in_valid.
